// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0), presented whenever no instruction is valid.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Widths of the default 32-bit configuration, used by fetch_entry_t.
  localparam int FETCH_AW = 32;
  localparam int FETCH_DW = 32;

  // FETCH: normal operation. DRAIN: waiting out a request made obsolete by a redirect.
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [FETCH_DW-1:0] instr;
    logic [FETCH_AW-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction queue holding {instr, pc} pairs between imem and the F/D register.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push is ignored when full, pop when empty; flush empties it and wins over both.
module fetch_buffer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_WIDTH-1:0]    push_instr,
  input  logic [ADDRESS_WIDTH-1:0] push_pc,
  output logic [1:0]               count,
  output logic [DATA_WIDTH-1:0]    head_instr,
  output logic [ADDRESS_WIDTH-1:0] head_pc
);

  logic [DATA_WIDTH-1:0]    instr_mem [2];
  logic [ADDRESS_WIDTH-1:0] pc_mem    [2];
  logic                     rd_ptr;
  logic                     wr_ptr;
  logic                     do_push;
  logic                     do_pop;

  // Guard against overflow/underflow so the pointers can never run past each other.
  assign do_push = push & (count != 2'd2);
  assign do_pop  = pop  & (count != 2'd0);

  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];

  // Pointer, occupancy and storage update; a flush discards everything in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      instr_mem[0] <= '0;
      instr_mem[1] <= '0;
      pc_mem[0]    <= '0;
      pc_mem[1]    <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        instr_mem[wr_ptr] <= push_instr;
        pc_mem[wr_ptr]    <= push_pc;
        wr_ptr            <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the fetch PC, requests imem over valid/ready, feeds rd/pcf/pcplus4f to F/D.
// Latency: 1 cycle from an accepted imem request to validf; 1 instr/cycle with zero-wait memory.
// Backpressure: stallf holds the head; requests stop at 2 buffered. Optional FETCH_PERF_EN adds counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stallf,
  input  logic                     pcsrce,
  input  logic [ADDRESS_WIDTH-1:0] pctargete,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ready,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [DATA_WIDTH-1:0]    rd,
  output logic [ADDRESS_WIDTH-1:0] pcf,
  output logic [ADDRESS_WIDTH-1:0] pcplus4f,
  output logic                     validf
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              fetch_count,
  output logic [31:0]              stall_count
`endif
);

  fetch_state_t             state_q;
  logic [ADDRESS_WIDTH-1:0] fetch_pc_q;
  logic [ADDRESS_WIDTH-1:0] drain_addr_q;
  logic [ADDRESS_WIDTH-1:0] target_aligned;
  logic                     req_want;
  logic                     push;
  logic                     pop;
  logic [1:0]               count;
  logic [DATA_WIDTH-1:0]    head_instr;
  logic [ADDRESS_WIDTH-1:0] head_pc;
  logic                     unused_target_lsbs;

  // Instructions are word aligned, so the low target bits carry no information.
  assign target_aligned     = {pctargete[ADDRESS_WIDTH-1:2], 2'b00};
  assign unused_target_lsbs = ^pctargete[1:0];

  // In DRAIN the stale request must be kept up until memory completes it. In FETCH a request
  // only goes out when a slot is free; with one request in flight it can never overflow.
  // Gating with rst_n drops the request the moment reset asserts.
  assign req_want  = (state_q == DRAIN) | (count != 2'd2);
  assign imem_req  = rst_n & req_want;
  assign imem_addr = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;

  // Responses are kept only in FETCH and never in the cycle a redirect arrives.
  assign push = imem_req & imem_ready & (state_q == FETCH) & ~pcsrce;
  assign pop  = validf & ~stallf;

  // Fetch PC and drain tracking; a redirect overrides every other update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      fetch_pc_q   <= {RESET_VECTOR[ADDRESS_WIDTH-1:2], 2'b00};
      drain_addr_q <= {RESET_VECTOR[ADDRESS_WIDTH-1:2], 2'b00};
    end else if (pcsrce) begin
      fetch_pc_q <= target_aligned;
      if (imem_req & ~imem_ready) begin
        // Request still in flight: hold its address until memory finishes with it.
        state_q      <= DRAIN;
        drain_addr_q <= imem_addr;
      end else begin
        state_q <= FETCH;
      end
    end else if (state_q == DRAIN) begin
      if (imem_ready) begin
        state_q <= FETCH;
      end
    end else if (push) begin
      fetch_pc_q <= fetch_pc_q + ADDRESS_WIDTH'(4);
    end
  end

  fetch_buffer #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (pcsrce),
    .push_instr (imem_rdata),
    .push_pc    (imem_addr),
    .count      (count),
    .head_instr (head_instr),
    .head_pc    (head_pc)
  );

  // Empty queue presents a NOP at PC 0 so the F/D register never latches stale data.
  assign validf   = (count != 2'd0);
  assign rd       = validf ? head_instr : DATA_WIDTH'(NOP_INSTR);
  assign pcf      = validf ? head_pc : '0;
  assign pcplus4f = pcf + ADDRESS_WIDTH'(4);

`ifdef FETCH_PERF_EN
  // Count delivered instructions and cycles where a valid head was held by a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (pop) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (validf & stallf) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Fetch stage of the 5-stage RISC-V pipeline; sits directly upstream of the F/D pipeline register and drives its rd, pcf and pcplus4f inputs.
Owns the fetch PC, issues requests to instruction memory over a valid/ready handshake, and buffers responses in a 2-entry queue.
Honours hazard-unit stall and execute-stage redirect (branch/jump), discarding wrong-path instructions.

Parameters:
ADDRESS_WIDTH, 32, PC/memory address width
DATA_WIDTH, 32, instruction width
RESET_VECTOR, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
stallf  in  1  hazard unit: downstream not accepting this cycle
pcsrce  in  1  redirect pulse from execute (taken branch/jump)
pctargete  in  ADDRESS_WIDTH  redirect target
imem_req  out  1  request valid to instruction memory
imem_addr  out  ADDRESS_WIDTH  request address, word-aligned
imem_ready  in  1  memory completes request; imem_rdata valid this cycle
imem_rdata  in  DATA_WIDTH  instruction data
rd  out  DATA_WIDTH  instruction to F/D register (NOP 32'h0000_0013 when validf=0)
pcf  out  ADDRESS_WIDTH  PC of rd (0 when validf=0)
pcplus4f  out  ADDRESS_WIDTH  pcf+4, modulo 2^ADDRESS_WIDTH
validf  out  1  rd/pcf hold a real instruction

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_VECTOR, queue count=0, state=FETCH; outputs validf=0, rd=NOP, pcf=0, pcplus4f=4, imem_req=0.
- Queue: 2 entries {instr, pc}; outputs driven from head; validf = (count!=0).
- pop = validf & !stallf; push = imem_req & imem_ready & state==FETCH & !pcsrce.
- Request: in FETCH, imem_req raised when count<2 (only one request outstanding, so overflow is impossible). Once imem_req=1 with imem_ready=0, imem_req and imem_addr must stay stable until imem_ready.
- imem_addr = fetch_pc; on push, fetch_pc <= fetch_pc+4 (wraps).
- Zero-wait memory (imem_ready tied 1), stallf=0: one instruction per cycle; first validf=1 one cycle after reset release; latency request->validf = 1 cycle.
- Stall: head held stable while stallf=1; requests continue until count=2.
- Redirect (pcsrce=1) has priority over push/pop/stall:
  - queue flushed; validf=0 next cycle.
  - fetch_pc <= {pctargete[ADDRESS_WIDTH-1:2],2'b00}.
  - If a request is outstanding and not completing this cycle: state->DRAIN.
  - If the request completes this cycle, its data is discarded.
- DRAIN: imem_req held at the old address until imem_ready; response discarded; then state->FETCH and the target is requested next cycle.
- Redirect during DRAIN: target updated, remain DRAIN.
- Simultaneous push and pop: count unchanged.
- Reset mid-request: imem_req drops immediately; memory must tolerate an abandoned request.

Optional Feature:
FETCH_PERF_EN: adds outputs fetch_count[31:0] (increments on each pop) and stall_count[31:0] (increments each cycle with validf&stallf). Both reset to 0 and wrap.
Without the macro, the ports and counters are absent.

Decomposition:
Package fetch_pkg:
- NOP_INSTR constant
- fetch_state_t enum {FETCH, DRAIN}
- fetch_entry_t struct {instr, pc}

Sub-module fetch_buffer: 2-entry queue with push/pop/flush, count and head outputs.

Test Plan:
- Reset release, imem_ready=1, stallf=0 -> pcf=0,4,8,12 on consecutive cycles from cycle 1; rd follows memory.
- stallf=1 for 3 cycles at pcf=8 -> pcf/rd held at 8, imem_req drops after 2 entries queued, resumes 12,16 after release.
- pcsrce=1, pctargete=0x100, while entries 12,16 queued -> validf=0 next cycle, then pcf=0x100,0x104; 12/16 never appear.
- Memory latency 3 cycles, redirect to 0x40 on the 2nd wait cycle -> imem_addr held at old value until ready, data dropped, next imem_addr=0x40.
- pctargete=0x103 -> imem_addr=0x100; at fetch_pc=0xFFFF_FFFC, pcplus4f=0.
- Assert rst_n=0 mid-request -> imem_req=0 and validf=0 immediately; first fetch after release is at RESET_VECTOR.
